// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the two-input gate truth-table sequencer.
package gate_tt_pkg;

  // Sequencer phases: one DRIVE/SETTLE/SAMPLE pass per input vector, then DONE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Number of input combinations of a two-input gate.
  localparam int unsigned NUM_VECTORS = 4;

  // Width of the settle down-counter; holds 0..255 settle cycles.
  localparam int unsigned CNT_W = 8;

  // Truth tables: bit i is the gate output for {A,B} = i.
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// Settle down-counter: loaded at the start of a settle window, decremented
// once per settle cycle, flags expiry when the last settle cycle is reached.
module gate_tt_settle_cnt
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // Counter register: clear wins over load, load over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
      r_count <= r_count - CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // Expiry marks the final settle cycle so the window lasts exactly the loaded count.
  assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: walks {A,B} through 00,01,10,11, waits for the gate
// under test to settle, samples its output against EXPECT and reports the run.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned                 SETTLE_CYCLES = 4,
  parameter logic [NUM_VECTORS-1:0]      EXPECT        = TT_NAND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   gate_y,
  output logic                   drv_a,
  output logic                   drv_b,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2:0]             err_count,
  output logic [NUM_VECTORS-1:0] fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [1:0]       LAST_IDX    = 2'(NUM_VECTORS - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [1:0]             r_idx;
  logic [2:0]             r_wcount;
  logic [NUM_VECTORS-1:0] r_wmask;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [2:0]             r_err_count;
  logic [NUM_VECTORS-1:0] r_fail_vec;

  logic                   w_abort_run;
  logic                   w_mismatch;
  logic [2:0]             w_count_fin;
  logic [NUM_VECTORS-1:0] w_mask_fin;
  logic                   w_cnt_clr;
  logic                   w_cnt_load;
  logic                   w_cnt_dec;
  logic                   w_cnt_expire;

  gate_tt_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_cnt_dec),
    .o_expire   (w_cnt_expire)
  );

  // Compare and working-result arithmetic, including the vector being sampled now.
  always_comb begin
    w_abort_run = 1'b0;
    if (r_state != ST_IDLE) begin
      w_abort_run = abort;
    end else begin
      w_abort_run = 1'b0;
    end
    w_mismatch  = (gate_y != EXPECT[r_idx]);
    w_count_fin = r_wcount + {2'b00, w_mismatch};
    w_mask_fin  = r_wmask | ({{(NUM_VECTORS-1){1'b0}}, w_mismatch} << r_idx);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and settle-counter control; abort of a live run overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    if (w_abort_run) begin
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          w_cnt_load = 1'b1;
          if (SETTLE_LOAD == {CNT_W{1'b0}}) begin
            w_state_nxt = ST_SAMPLE;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          w_cnt_dec = 1'b1;
          if (w_cnt_expire) begin
            w_state_nxt = ST_SAMPLE;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DRIVE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SETTLE) ||
                (w_state_nxt == ST_SAMPLE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  // Vector index, working tallies and published results; results only move at run end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_wcount    <= 3'd0;
      r_wmask     <= {NUM_VECTORS{1'b0}};
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= {NUM_VECTORS{1'b0}};
    end else if (w_abort_run) begin
      r_idx <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_idx    <= 2'd0;
            r_wcount <= 3'd0;
            r_wmask  <= {NUM_VECTORS{1'b0}};
          end
        end
        ST_SAMPLE: begin
          r_wcount <= w_count_fin;
          r_wmask  <= w_mask_fin;
          if (r_idx == LAST_IDX) begin
            r_fail_vec  <= w_mask_fin;
            r_err_count <= w_count_fin;
            r_pass      <= (w_count_fin == 3'd0);
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign drv_a     = r_idx[1];
  assign drv_b     = r_idx[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule
